// File: rtl/fre_meas_sched.sv
// rtl/fre_meas_sched.sv - time-shares one reciprocal M/N frequency measurer across CH_NUM channels
`timescale 1ns/1ps
module fre_meas_sched #(
    parameter int          CH_NUM     = 4,
    parameter int          CH_W       = $clog2(CH_NUM),
    parameter int          CLR_CYC    = 4,
    parameter int          SETTLE_CYC = 16,
    parameter int          DISCARD_N  = 1,
    parameter logic [31:0] TIMEOUT    = 32'd250_000_000
) (
    input  logic              clk_100M,
    input  logic              rst,
    input  logic              run,
    input  logic [CH_NUM-1:0] ch_en,
    input  logic              req_valid,
    input  logic [CH_W-1:0]   req_ch,
    output logic              req_ready,
    input  logic              irq_in,
    input  logic [31:0]       M_in,
    input  logic [31:0]       N_in,
    output logic [CH_W-1:0]   sel,
    output logic              meas_clr,
    output logic              busy,
    output logic              res_valid,
    output logic [CH_W-1:0]   res_ch,
    output logic [31:0]       res_M,
    output logic [31:0]       res_N,
    output logic              res_to
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SWITCH,
        S_SETTLE,
        S_DISCARD,
        S_WAIT,
        S_CAPTURE,
        S_NEXT
    } state_t;

    state_t            state_q, state_d;
    logic [CH_W-1:0]   sel_q, sel_d;
    logic [CH_W-1:0]   rr_q, rr_d;
    logic [CH_W-1:0]   rr_pick, rr_idx;
    logic              rr_found;
    logic [15:0]       cnt_q, cnt_d;
    logic [31:0]       to_q, to_d, to_nxt;
    logic [7:0]        disc_q, disc_d, disc_nxt;
    logic              irq_q, irq_fall, timed_out;
    logic              clr_q, busy_q;
    logic              req_ready_q, req_ready_d;
    logic              res_valid_q, res_valid_d;
    logic [CH_W-1:0]   res_ch_q, res_ch_d;
    logic [31:0]       res_m_q, res_m_d, res_n_q, res_n_d;
    logic              res_to_q, res_to_d;

    assign irq_fall  = irq_q & ~irq_in;
    assign to_nxt    = to_q + 32'd1;
    assign timed_out = (to_nxt >= TIMEOUT);
    assign disc_nxt  = disc_q + 8'd1;

    // First enabled channel strictly after the last scanned one, wrapping.
    always_comb begin
        rr_pick  = rr_q;
        rr_found = 1'b0;
        rr_idx   = '0;
        for (int i = 1; i <= CH_NUM; i++) begin
            rr_idx = CH_W'((int'(rr_q) + i) % CH_NUM);
            if (!rr_found && ch_en[rr_idx]) begin
                rr_pick  = rr_idx;
                rr_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        rr_d        = rr_q;
        cnt_d       = cnt_q;
        to_d        = to_q;
        disc_d      = disc_q;
        req_ready_d = 1'b0;
        res_valid_d = 1'b0;
        res_ch_d    = res_ch_q;
        res_m_d     = res_m_q;
        res_n_d     = res_n_q;
        res_to_d    = res_to_q;
        case (state_q)
            S_IDLE, S_NEXT: begin
                // Host requests do not move the round-robin pointer.
                if (req_valid) begin
                    state_d     = S_SWITCH;
                    sel_d       = req_ch;
                    req_ready_d = 1'b1;
                    cnt_d       = '0;
                end else if (run && rr_found) begin
                    state_d = S_SWITCH;
                    sel_d   = rr_pick;
                    rr_d    = rr_pick;
                    cnt_d   = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SWITCH: begin
                if (cnt_q == 16'(CLR_CYC - 1)) begin
                    state_d = S_SETTLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_SETTLE: begin
                if (cnt_q == 16'(SETTLE_CYC - 1)) begin
                    state_d = (DISCARD_N == 0) ? S_WAIT : S_DISCARD;
                    to_d    = '0;
                    disc_d  = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_DISCARD: begin
                to_d = to_nxt;
                if (timed_out) begin
                    state_d     = S_NEXT;
                    res_valid_d = 1'b1;
                    res_ch_d    = sel_q;
                    res_m_d     = '0;
                    res_n_d     = '0;
                    res_to_d    = 1'b1;
                end else if (irq_fall) begin
                    disc_d = disc_nxt;
                    if (disc_nxt >= 8'(DISCARD_N)) begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                to_d = to_nxt;
                // A gate ending on the timeout cycle is still a valid measurement.
                if (irq_fall) begin
                    state_d = S_CAPTURE;
                end else if (timed_out) begin
                    state_d     = S_NEXT;
                    res_valid_d = 1'b1;
                    res_ch_d    = sel_q;
                    res_m_d     = '0;
                    res_n_d     = '0;
                    res_to_d    = 1'b1;
                end
            end
            S_CAPTURE: begin
                state_d     = S_NEXT;
                res_valid_d = 1'b1;
                res_ch_d    = sel_q;
                res_m_d     = M_in;
                res_n_d     = N_in;
                res_to_d    = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_100M or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            sel_q       <= '0;
            rr_q        <= CH_W'(CH_NUM - 1);
            cnt_q       <= '0;
            to_q        <= '0;
            disc_q      <= '0;
            irq_q       <= 1'b0;
            clr_q       <= 1'b1;
            busy_q      <= 1'b0;
            req_ready_q <= 1'b0;
            res_valid_q <= 1'b0;
            res_ch_q    <= '0;
            res_m_q     <= '0;
            res_n_q     <= '0;
            res_to_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            rr_q        <= rr_d;
            cnt_q       <= cnt_d;
            to_q        <= to_d;
            disc_q      <= disc_d;
            irq_q       <= irq_in;
            clr_q       <= (state_d == S_SWITCH);
            busy_q      <= (state_d != S_IDLE);
            req_ready_q <= req_ready_d;
            res_valid_q <= res_valid_d;
            res_ch_q    <= res_ch_d;
            res_m_q     <= res_m_d;
            res_n_q     <= res_n_d;
            res_to_q    <= res_to_d;
        end
    end

    assign sel       = sel_q;
    assign meas_clr  = clr_q;
    assign busy      = busy_q;
    assign req_ready = req_ready_q;
    assign res_valid = res_valid_q;
    assign res_ch    = res_ch_q;
    assign res_M     = res_m_q;
    assign res_N     = res_n_q;
    assign res_to    = res_to_q;

endmodule

// File: tb/tb_fre_meas_sched.sv
// tb/tb_fre_meas_sched.sv - scoreboard bench for fre_meas_sched with a behavioural gate generator
`timescale 1ns/1ps
module tb_fre_meas_sched;

    localparam int          CH_NUM     = 4;
    localparam int          CH_W       = 2;
    localparam int          CLR_CYC    = 4;
    localparam int          SETTLE_CYC = 16;
    localparam int          DISCARD_N  = 1;
    localparam logic [31:0] TIMEOUT    = 32'd5000;

    logic              clk;
    logic              rst;
    logic              run;
    logic [CH_NUM-1:0] ch_en;
    logic              req_valid;
    logic [CH_W-1:0]   req_ch;
    logic              req_ready;
    logic              irq_in;
    logic [31:0]       M_in;
    logic [31:0]       N_in;
    logic [CH_W-1:0]   sel;
    logic              meas_clr;
    logic              busy;
    logic              res_valid;
    logic [CH_W-1:0]   res_ch;
    logic [31:0]       res_M;
    logic [31:0]       res_N;
    logic              res_to;

    typedef struct {
        logic [CH_W-1:0] ch;
        logic [31:0]     m;
        logic [31:0]     n;
        logic            to;
    } res_t;

    res_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   mode = 0;     // 0: periodic gates, 1: irq held low, 2: driven by hand
    int   gates = 0;
    int   fall_cyc = 0;
    int   clr_drop_cyc = 0;
    int   ph = 0;

    fre_meas_sched #(
        .CH_NUM(CH_NUM), .CH_W(CH_W), .CLR_CYC(CLR_CYC), .SETTLE_CYC(SETTLE_CYC),
        .DISCARD_N(DISCARD_N), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_100M(clk), .rst(rst), .run(run), .ch_en(ch_en),
        .req_valid(req_valid), .req_ch(req_ch), .req_ready(req_ready),
        .irq_in(irq_in), .M_in(M_in), .N_in(N_in),
        .sel(sel), .meas_clr(meas_clr), .busy(busy),
        .res_valid(res_valid), .res_ch(res_ch), .res_M(res_M), .res_N(res_N), .res_to(res_to)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input int ch, input longint m, input longint n, input bit to);
        res_t e;
        e.ch = CH_W'(ch);
        e.m  = 32'(m);
        e.n  = 32'(n);
        e.to = to;
        sb.push_back(e);
    endtask

    task automatic push_ch(input int ch);
        push(ch, ch * 100, ch * 7, 1'b0);
    endtask

    task automatic manual_fall(input logic [31:0] m, input logic [31:0] n);
        irq_in   = 1'b0;
        M_in     = m;
        N_in     = n;
        gates    = gates + 1;
        fall_cyc = cyc;
    endtask

    // Measurer model: cleared by meas_clr, first gate ends 500 cycles after clear, then every 1000.
    initial begin
        irq_in = 1'b1;
        M_in   = '0;
        N_in   = '0;
        forever begin
            @(negedge clk);
            if (meas_clr) begin
                ph    = 0;
                gates = 0;
                if (mode == 0) irq_in = 1'b1;
            end else if (mode == 0) begin
                ph++;
                if (ph % 1000 == 500) begin
                    irq_in   = 1'b0;
                    M_in     = 32'(sel) * 32'd100;
                    N_in     = 32'(sel) * 32'd7;
                    gates    = gates + 1;
                    fall_cyc = cyc;
                end else if (ph % 1000 == 0) begin
                    irq_in = 1'b1;
                end
            end
            if (mode == 1) irq_in = 1'b0;
        end
    end

    initial begin
        logic prev_clr;
        int   clr_w;
        bit   armed;
        res_t e;
        prev_clr = 1'b1;
        clr_w    = 0;
        armed    = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                prev_clr = 1'b1;
                armed    = 1'b0;
            end else begin
                if (meas_clr && !prev_clr) begin
                    armed = 1'b1;
                    clr_w = 1;
                end else if (meas_clr) begin
                    clr_w++;
                end else if (prev_clr) begin
                    clr_drop_cyc = cyc;
                    if (armed) chk("clr_width", longint'(clr_w), longint'(CLR_CYC));
                    armed = 1'b0;
                end
                prev_clr = meas_clr;
                if (res_valid) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_res", longint'(res_valid), 0);
                    end else begin
                        e = sb.pop_front();
                        chk("res_ch", longint'(res_ch), longint'(e.ch));
                        chk("res_M", longint'(res_M), longint'(e.m));
                        chk("res_N", longint'(res_N), longint'(e.n));
                        chk("res_to", longint'(res_to), longint'(e.to));
                        if (e.to) begin
                            chk("to_latency", longint'(cyc - clr_drop_cyc),
                                longint'(SETTLE_CYC) + longint'(TIMEOUT));
                        end else begin
                            chk("gates_seen", longint'(gates), longint'(DISCARD_N + 1));
                            chk("cap_latency", longint'(cyc - fall_cyc), 2);
                        end
                    end
                end
            end
        end
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_sel"}, longint'(sel), 0);
        chk({tag, "_clr"}, longint'(meas_clr), 1);
        chk({tag, "_busy"}, longint'(busy), 0);
        chk({tag, "_req_ready"}, longint'(req_ready), 0);
        chk({tag, "_res_valid"}, longint'(res_valid), 0);
        chk({tag, "_res_ch"}, longint'(res_ch), 0);
        chk({tag, "_res_M"}, longint'(res_M), 0);
        chk({tag, "_res_N"}, longint'(res_N), 0);
        chk({tag, "_res_to"}, longint'(res_to), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        run       = 1'b0;
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("clr_after_rst", longint'(meas_clr), 0);
    endtask

    task automatic wait_empty(input int max);
        int t = 0;
        while (sb.size() != 0 && t < max) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            chk("sb_drain", longint'(sb.size()), 0);
            sb.delete();
        end
    endtask

    task automatic wait_idle(input int max);
        int t = 0;
        while (busy && t < max) begin
            @(negedge clk);
            t++;
        end
        chk("idle", longint'(busy), 0);
    endtask

    initial begin
        int t;
        int d;
        rst = 1'b1; run = 1'b0; ch_en = '0; req_valid = 1'b0; req_ch = '0;
        repeat (3) @(negedge clk);
        chk_reset_vals("por");
        rst = 1'b0;
        @(negedge clk);
        chk("clr_first_clk", longint'(meas_clr), 0);

        // Round-robin over ch0/ch2
        do_reset();
        mode = 0; ch_en = 4'b0101;
        push_ch(0); push_ch(2); push_ch(0); push_ch(2);
        run = 1'b1;
        wait_empty(8000);
        run = 1'b0;
        wait_idle(4000);

        // No signal on ch1 -> timeout result
        do_reset();
        mode = 1; ch_en = 4'b0010;
        push(1, 0, 0, 1'b1);
        run = 1'b1;
        wait_empty(8000);
        run = 1'b0;
        wait_idle(8000);
        mode = 0;

        // One-shot request while not scanning
        do_reset();
        ch_en = 4'b0000;
        push_ch(3);
        req_valid = 1'b1; req_ch = 2'd3;
        @(negedge clk);
        chk("req_ready", longint'(req_ready), 1);
        chk("req_sel", longint'(sel), 3);
        chk("req_clr", longint'(meas_clr), 1);
        chk("req_busy", longint'(busy), 1);
        req_valid = 1'b0;
        @(negedge clk);
        chk("req_ready_pulse", longint'(req_ready), 0);
        wait_empty(4000);
        wait_idle(100);

        // Request during a scan takes priority at NEXT; scan then resumes after ch0
        do_reset();
        ch_en = 4'b1111;
        push_ch(0); push_ch(2); push_ch(1);
        run = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!(busy && !meas_clr) && t < 200);
        req_valid = 1'b1; req_ch = 2'd2;
        t = 0;
        while (sb.size() != 0 && t < 8000) begin
            @(negedge clk);
            t++;
            if (req_valid && req_ready) begin
                chk("prio_sel", longint'(sel), 2);
                req_valid = 1'b0;
            end
        end
        run = 1'b0;
        chk("prio_accepted", longint'(req_valid), 0);
        req_valid = 1'b0;
        wait_empty(10);
        wait_idle(4000);

        // Reset in the middle of a WAIT
        do_reset();
        ch_en = 4'b0110;
        push_ch(1);
        run = 1'b1;
        wait_empty(4000);
        t = 0;
        while (!meas_clr && t < 100) begin @(negedge clk); t++; end
        t = 0;
        while (gates != 1 && t < 3000) begin @(negedge clk); t++; end
        repeat (50) @(negedge clk);
        chk("sel_before_rst", longint'(sel), 2);
        rst = 1'b1;
        #1;
        chk_reset_vals("midrst");
        run = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        ch_en = 4'b1111;
        push_ch(0);
        @(negedge clk);
        run = 1'b1;
        wait_empty(4000);
        run = 1'b0;
        wait_idle(4000);

        // Final gate lands exactly on the timeout cycle
        do_reset();
        mode = 2; irq_in = 1'b1;
        push(1, 1234, 567, 1'b0);
        req_valid = 1'b1; req_ch = 2'd1;
        @(negedge clk);
        req_valid = 1'b0;
        t = 0;
        while (meas_clr && t < 100) begin @(negedge clk); t++; end
        d = clr_drop_cyc + SETTLE_CYC;
        while (cyc < d + 100) @(negedge clk);
        manual_fall(32'd777, 32'd55);
        while (cyc < d + 200) @(negedge clk);
        irq_in = 1'b1;
        while (cyc < d + int'(TIMEOUT) - 1) @(negedge clk);
        manual_fall(32'd1234, 32'd567);
        wait_empty(100);
        wait_idle(100);
        mode = 0;

        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fre_meas_sched.md
# fre_meas_sched

Measurement scheduler that time-shares one frequency-measurement datapath (reciprocal M/N counter with gate/irq output) among `CH_NUM` input channels. It selects a channel, clears the measurer, discards stale gates, captures the M/N pair of the first clean gate, and flags channels with no signal via a timeout. It runs continuous round-robin or serves one-shot host requests, and presents one tagged result per measurement to the register/readout layer.

## Interface
- `CH_NUM`, 4: number of input channels, 2..16; `CH_W` = clog2(`CH_NUM`).
- `CLR_CYC`, 4: cycles `meas_clr` is held high on each channel switch.
- `SETTLE_CYC`, 16: cycles waited after `meas_clr` drops, covering sync-chain and mux latency.
- `DISCARD_N`, 1: completed gates ignored after a switch before capture.
- `TIMEOUT`, 250_000_000: maximum cycles from end of SETTLE to capture; 32-bit.
- `clk_100M` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `run` in 1: level; 1 enables continuous round-robin scanning.
- `ch_en` in `CH_NUM`: per-channel scan enable mask.
- `req_valid` in 1: one-shot request for channel `req_ch`.
- `req_ch` in `CH_W`: requested channel.
- `req_ready` out 1: one-cycle accept pulse.
- `irq_in` in 1: gate from the measurer; falling edge = measurement complete, `M_in`/`N_in` stable from that edge until the next rising edge.
- `M_in`, `N_in` in 32: reference and signal counts from the measurer.
- `sel` out `CH_W`: channel mux select to the measurer input.
- `meas_clr` out 1: active-high clear to the measurer.
- `busy` out 1: high whenever state ≠ IDLE.
- `res_valid` out 1: one-cycle result pulse.
- `res_ch` out `CH_W`, `res_M` out 32, `res_N` out 32, `res_to` out 1: result channel, counts, timeout flag. Held until the next `res_valid`.

## Operation
- States: IDLE, SWITCH, SETTLE, DISCARD, WAIT, CAPTURE, NEXT.
- IDLE: if `req_valid`, go to SWITCH with `sel`←`req_ch` and pulse `req_ready`. Otherwise, if `run` and `ch_en`≠0, go to SWITCH with `sel`←the first enabled channel after the last scanned one (wrapping; after reset the search starts at channel 0). Otherwise stay.
- SWITCH: `meas_clr`=1 for `CLR_CYC` cycles, then SETTLE.
- SETTLE: wait `SETTLE_CYC` cycles, clear the timeout counter and discard counter, then DISCARD (or WAIT if `DISCARD_N`=0).
- DISCARD: count `irq_in` falling edges. At `DISCARD_N`, go to WAIT.
- WAIT: on an `irq_in` falling edge, go to CAPTURE.
- CAPTURE: latch `M_in`/`N_in` into `res_M`/`res_N`, set `res_ch`=`sel`, `res_to`=0, pulse `res_valid`. Go to NEXT.
- Timeout: in DISCARD or WAIT, when the counter reaches `TIMEOUT`, go to NEXT. Pulse `res_valid` with `res_to`=1 and `res_M`=`res_N`=0.
- NEXT: behaves like IDLE arbitration. A pending `req_valid` has priority over round-robin. If `run` is 0 or `ch_en`=0, and no request is pending, go to IDLE.
- Edge detection: register `irq_in` once; falling edge = prev 1 & cur 0. `irq_in` is already synchronous to `clk_100M`.
- A request for a channel that is disabled in `ch_en` is still served.
- Changes to `ch_en` or `run` mid-measurement do not abort the measurement. They take effect at NEXT.
- `req_valid` must stay high until `req_ready`. Requests are only accepted in IDLE or NEXT.

## Timing
- Reset values: `sel`=0, `meas_clr`=1, `busy`=0, `req_ready`=0, `res_valid`=0, `res_ch`=0, `res_M`=0, `res_N`=0, `res_to`=0, state IDLE, round-robin pointer = `CH_NUM`−1.
- `meas_clr` drops on the first clock after reset release, so the measurer is held cleared through reset.
- Reset asserted mid-operation returns to the reset values immediately, asynchronously.
- All outputs are registered.
- IDLE→SWITCH: 1 cycle after the trigger. `sel` changes on the same edge that `meas_clr` rises.
- Capture latency: `res_valid` is asserted 2 cycles after the `irq_in` falling edge at the input (1 cycle edge register, 1 cycle CAPTURE).
- Minimum channel-to-channel overhead, excluding gates: 1 + `CLR_CYC` + `SETTLE_CYC` + 1 cycles.
- Timeout count includes DISCARD time. It is compared with ≥ so a 32-bit wrap is impossible.
- Simultaneous falling edge and timeout on the same cycle: the capture wins, `res_to`=0.

## Test plan
- Reset release, `run`=1, `ch_en`=4'b0101, irq gates every 1000 cycles with M/N = ch×100 / ch×7 → results alternate ch0, ch2, ch0…; each is preceded by a 4-cycle `meas_clr`, and the first gate after SETTLE is discarded.
- Channel 1 enabled, `irq_in` held 0, `TIMEOUT`=5000 → `res_valid` with `res_to`=1, `res_ch`=1, M=N=0, exactly 5000 cycles after SETTLE ends.
- `run`=0, `req_valid` with `req_ch`=3 → `req_ready` 1 cycle later, `sel`=3, one result, return to IDLE with `busy`=0.
- During a ch0 measurement with `run`=1, raise `req_valid` for ch2 and hold it → ch0 completes, ch2 is served next, then round-robin resumes at ch1.
- `rst` pulsed mid-WAIT → all outputs return to reset values in the same cycle, no `res_valid`; scanning restarts at ch0.
- Falling edge on the cycle the counter hits `TIMEOUT` → the captured values are reported with `res_to`=0.
